pe_row_ctrl: RTL
================

Name: pe_row_ctrl

Overview:
- Sequencer for a 1-D row of NUM_PE shift-and-add PEs in the map-inflation convolution datapath.
- Loads one weight per PE, then streams a frame of pixels into PE 0 through a valid/ready handshake.
- Generates a skewed per-PE enable as each pixel ripples down the row.
- Flags the cycles in which each PE output holds a valid product, drains the pipeline, and pulses done.

Parameters:
NUM_PE, 4, number of PEs in the row
DATA_WIDTH, 8, pixel width
WEIGHT_WIDTH, 8, weight width
LEN_WIDTH, 16, width of frame pixel count
PIX_HOP, 2, cycles for a pixel to travel from PE k to PE k+1
PE_LATENCY, 2, cycles from pe_en[k] to a valid product on PE k output

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a job; sampled only in IDLE
frame_len  in  LEN_WIDTH  pixels in the frame; latched on accepted start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of job
w_valid  in  1  weight word valid
w_data  in  WEIGHT_WIDTH  weight word; the first accepted word goes to PE 0
w_ready  out  1  high only in LOAD_W
s_valid  in  1  pixel valid
s_data  in  DATA_WIDTH  pixel
s_ready  out  1  high only in STREAM
pe_weight  out  NUM_PE*WEIGHT_WIDTH  weight bank; PE k uses slice [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
pe_input  out  DATA_WIDTH  registered pixel into PE 0
pe_en  out  NUM_PE  per-PE compute enable
res_valid  out  NUM_PE  PE k output valid this cycle

Behaviour:
- Reset: all outputs 0, weight bank 0, all counters 0, delay lines cleared, state IDLE. rst mid-job aborts immediately; no done pulse.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on start. Latch frame_len; clear weight index and pixel counter. start in any other state is ignored.
- LOAD_W: each w_valid&&w_ready writes w_data into bank[widx] and increments widx.
  - After NUM_PE writes: go to STREAM, or go directly to DRAIN if the latched frame_len == 0.
  - pe_weight updates as each word is written and is then held constant until the next job's LOAD_W.
- STREAM: accept = s_valid&&s_ready.
  - On accept: pe_input <= s_data on the next edge; pixel counter increments.
  - pe_input holds its value when there is no accept.
  - On the accept that brings the count to frame_len, s_ready drops the next cycle and the FSM enters DRAIN.
  - Bubbles (s_valid low) are legal. They propagate as gaps in pe_en and res_valid.
- Timing, with accept at cycle t:
  - pe_en[k] is high exactly at cycle t+1+k*PIX_HOP.
  - res_valid[k] is high exactly at cycle t+1+k*PIX_HOP+PE_LATENCY.
  - Implemented as a single shift line of depth 1+(NUM_PE-1)*PIX_HOP+PE_LATENCY, tapped per PE. Back-to-back accepts yield back-to-back enables.
- DRAIN: down-counter loaded with D = (NUM_PE-1)*PIX_HOP+PE_LATENCY+1. Decrement each cycle; at 0 go to DONE. The delay line keeps shifting, so every in-flight pixel emits its res_valid pulses before done.
- DONE: done=1 for one cycle, then IDLE. busy is low from the cycle after DONE.
- Counters: the pixel counter is LEN_WIDTH bits and never wraps, because the transition to DRAIN happens at equality. frame_len = 2^LEN_WIDTH-1 must be supported.
- No output backpressure: PE results must be consumed on the res_valid cycle.

Optional Feature:
- Macro: PE_ROW_CTRL_PERF_EN.
- Defined: adds outputs perf_busy_cycles and perf_stall_cycles, 32 bits each.
  - Both clear on accepted start and on rst.
  - busy_cycles counts cycles with busy=1.
  - stall_cycles counts STREAM cycles with s_valid=0.
  - Both saturate at 2^32-1 and hold their value after done.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset and weight load, defaults, weights 1,2,3,4: after 4 handshakes, pe_weight = 0x04030201, FSM enters STREAM.
- Continuous stream, frame_len=3, s_valid held high: accepts at t, t+1, t+2.
  - pe_en[0] high at t+1..t+3; pe_en[3] high at t+7..t+9; res_valid[3] high at t+9..t+11.
  - done pulses once after the drain, with D = 9 cycles.
- Bubble: frame_len=2, s_valid pattern 1,0,1 -> pe_en[0] pattern 1,0,1, repeated on every tap with gaps preserved.
- Zero length: frame_len=0 -> s_ready never asserts, pe_en stays 0, done pulses D+1 cycles after leaving LOAD_W.
- Abort: rst=1 for one cycle mid-STREAM after 1 of 5 pixels.
  - Next cycle: busy=0, pe_en=0, res_valid=0, pe_weight=0.
  - A start during STREAM is ignored and frame_len stays unchanged.
- PERF_EN: frame_len=4 with 2 bubbles -> perf_stall_cycles = 2 and perf_busy_cycles = total busy cycles, both held after done.

Source files
------------

// File: rtl/pe_row_ctrl_if.sv
// rtl/pe_row_ctrl_if.sv - weight and pixel valid/ready channels into the PE row sequencer
interface pe_row_ctrl_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8
);
  logic                    w_valid;
  logic [WEIGHT_WIDTH-1:0] w_data;
  logic                    w_ready;
  logic                    s_valid;
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_ready;

  modport master (output w_valid, w_data, s_valid, s_data, input w_ready, s_ready);
  modport slave  (input w_valid, w_data, s_valid, s_data, output w_ready, s_ready);
endinterface

// File: rtl/pe_row_ctrl.sv
// rtl/pe_row_ctrl.sv - PE row sequencer: weight load, pixel stream, skewed enables, drain, done
// Optional perf counters enabled by defining PE_ROW_CTRL_PERF_EN.
module pe_row_ctrl #(
  parameter int NUM_PE       = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LEN_WIDTH    = 16,
  parameter int PIX_HOP      = 2,
  parameter int PE_LATENCY   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           frame_len,
  output logic                           busy,
  output logic                           done,
  pe_row_ctrl_if.slave                   bus,
  output logic [NUM_PE*WEIGHT_WIDTH-1:0] pe_weight,
  output logic [DATA_WIDTH-1:0]          pe_input,
  output logic [NUM_PE-1:0]              pe_en,
  output logic [NUM_PE-1:0]              res_valid
`ifdef PE_ROW_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_busy_cycles,
  output logic [31:0]                    perf_stall_cycles
`endif
);
  localparam int DEPTH     = 1 + (NUM_PE-1)*PIX_HOP + PE_LATENCY;
  localparam int DRAIN_CYC = (NUM_PE-1)*PIX_HOP + PE_LATENCY + 1;
  localparam int IW        = $clog2(NUM_PE+1);
  localparam int DCW       = $clog2(DRAIN_CYC+1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] pix_cnt;
  logic [IW-1:0]        widx;
  logic [DCW-1:0]       drain_cnt;
  logic [DEPTH-1:0]     dline;
  logic                 w_fire, s_fire, last_w, last_pix;

  // Fire terms use the state directly so the ready outputs stay out of any comb loop.
  assign w_fire   = bus.w_valid && (state == LOAD_W);
  assign s_fire   = bus.s_valid && (state == STREAM);
  assign last_w   = (widx == IW'(NUM_PE-1));
  assign last_pix = ((pix_cnt + LEN_WIDTH'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    bus.w_ready = 1'b0;
    bus.s_ready = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LOAD_W;
      LOAD_W: begin
        bus.w_ready = 1'b1;
        if (w_fire && last_w) state_nxt = (len_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        bus.s_ready = 1'b1;
        if (s_fire && last_pix) state_nxt = DRAIN;
      end
      DRAIN:  if (drain_cnt == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      pix_cnt   <= '0;
      widx      <= '0;
      drain_cnt <= '0;
      dline     <= '0;
      pe_weight <= '0;
      pe_input  <= '0;
    end else begin
      // One bit per accepted pixel; bubbles travel down the row as zeros.
      dline <= {dline[DEPTH-2:0], s_fire};
      if (state == IDLE && start) begin
        len_q   <= frame_len;
        widx    <= '0;
        pix_cnt <= '0;
      end
      if (w_fire) begin
        pe_weight[widx*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= bus.w_data;
        widx <= widx + IW'(1);
      end
      if (s_fire) begin
        pe_input <= bus.s_data;
        pix_cnt  <= pix_cnt + LEN_WIDTH'(1);
      end
      if (state_nxt == DRAIN && state != DRAIN)
        drain_cnt <= DCW'(DRAIN_CYC);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DCW'(1);
    end
  end

  for (genvar k = 0; k < NUM_PE; k++) begin : g_tap
    assign pe_en[k]     = dline[k*PIX_HOP];
    assign res_valid[k] = dline[k*PIX_HOP + PE_LATENCY];
  end

`ifdef PE_ROW_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == STREAM && !bus.s_valid && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
